alu_muldiv: RTL

- Next-generation execute unit: the base integer ALU operations plus the RV32M multiply/divide set, width-parametrised.
- Sits in the EX stage. Accepts one operation per valid/ready handshake and returns a registered result on a valid/ready output.
- Base ops complete in 1 cycle. MUL*/DIV*/REM* run iteratively over DATA_WIDTH cycles, so the pipeline stalls on in_ready/out_valid.

---
 rtl/alu_muldiv.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage execute unit.
// Base integer ALU ops finish one cycle after acceptance. The RV32M
// multiply/divide group runs a radix-2 iteration (shift-add multiply,
// restoring divide) over DATA_WIDTH cycles on operand magnitudes, and
// applies the sign fix-up as the result is written.
//
// Handshake: an operation is taken on a rising edge where in_valid and
// in_ready are both high. A result is handed over on a rising edge where
// out_valid and out_ready are both high. While out_valid is high and
// out_ready is low, ALUResult/Zero hold and out_valid stays high.
// in_ready is high in IDLE, or in DONE when out_ready is high (so the
// next op can enter with no bubble), and is forced low while flush is high.
module alu_muldiv #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero,
  output logic                     busy,
  output logic [1:0]               o_dbg_state
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(W);
  localparam int CW  = $clog2(W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0]  CNT_LOAD = CW'(W);
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  // Control state
  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [1:0]    w_acc_state;
  logic [CW-1:0] r_cnt;

  // Iteration datapath: r_hi is product-high / partial remainder,
  // r_lo is multiplier-then-product-low / dividend-then-quotient,
  // r_opb is multiplicand / divisor magnitude.
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_opb;
  logic [1:0]    r_mop;
  logic          r_neg;

  // Registered outputs
  logic [W-1:0]  r_result;
  logic          r_zero;

  // Accept-side decode
  logic          w_accept;
  logic          w_is_m;
  logic          w_is_div;
  logic          w_is_rem;
  logic [2:0]    w_mop;
  logic          w_sa;
  logic          w_sb;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [W-1:0]  w_a_mag;
  logic [W-1:0]  w_b_mag;
  logic          w_neg_acc;
  logic          w_div_zero;
  logic          w_div_ovf;
  logic          w_special;
  logic [W-1:0]  w_special_res;
  logic [SHW-1:0] w_shamt;
  logic [W-1:0]  w_base;

  // Iteration step
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0]   w_mul_res;
  logic [W:0]     w_div_shift;
  logic [W:0]     w_div_diff;
  logic           w_div_ge;
  logic [W-1:0]   w_rem_next;
  logic [W-1:0]   w_quo_next;
  logic [W-1:0]   w_div_res;
  logic           w_last;

  assign in_ready    = !flush && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_MUL) || (r_state == S_DIV);
  assign ALUResult   = r_result;
  assign Zero        = r_zero;
  assign o_dbg_state = r_state;

  // Base ALU result, computed straight from the live operands
  always_comb begin
    w_shamt = SrcB[SHW-1:0];
    w_base  = '0;
    case (Operation[3:0])
      4'b0000: w_base = SrcA & SrcB;
      4'b0001: w_base = SrcA | SrcB;
      4'b0010: w_base = SrcA + SrcB;
      4'b0011: w_base = SrcA ^ SrcB;
      4'b0110: w_base = SrcA - SrcB;
      4'b0111: w_base = {{(W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'b1000: w_base = {{(W-1){1'b0}}, (SrcA == SrcB)};
      4'b0100: w_base = SrcA << w_shamt;
      4'b0101: w_base = SrcA >> w_shamt;
      4'b1001: w_base = $unsigned($signed(SrcA) >>> w_shamt);
      4'b1010: w_base = {{(W-1){1'b0}}, (SrcA != SrcB)};
      4'b1011: w_base = {{(W-1){1'b0}}, ($signed(SrcA) >= $signed(SrcB))};
      default: w_base = '0;
    endcase
  end

  // M-group decode: signedness, magnitudes, result sign, special cases
  always_comb begin
    w_is_m    = Operation[4];
    w_mop     = Operation[2:0];
    w_is_div  = w_mop[2];
    w_is_rem  = w_mop[1];
    // MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed
    w_sa      = (w_mop == 3'b001) || (w_mop == 3'b010) || (w_mop == 3'b100) || (w_mop == 3'b110);
    w_sb      = (w_mop == 3'b001) || (w_mop == 3'b100) || (w_mop == 3'b110);
    w_a_neg   = w_sa && SrcA[W-1];
    w_b_neg   = w_sb && SrcB[W-1];
    w_a_mag   = w_a_neg ? (~SrcA + ONE_W) : SrcA;
    w_b_mag   = w_b_neg ? (~SrcB + ONE_W) : SrcB;
    // Remainder takes the dividend's sign; everything else the XOR
    w_neg_acc = (w_is_div && w_is_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = (SrcB == '0);
    w_div_ovf  = !w_mop[0] && (SrcA == MIN_NEG) && (SrcB == '1);
    w_special  = w_is_div && (w_div_zero || w_div_ovf);
    if (w_div_zero) begin
      w_special_res = w_is_rem ? SrcA : '1;
    end else begin
      w_special_res = w_is_rem ? '0 : SrcA;
    end
  end

  // One radix-2 step of multiply and divide, plus sign fix-up of the final step
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_prod      = {w_mul_sum, r_lo[W-1:1]};
    w_prod_fix  = r_neg ? (~w_prod + ONE_2W) : w_prod;
    w_mul_res   = (r_mop == 2'b00) ? w_prod_fix[W-1:0] : w_prod_fix[2*W-1:W];

    w_div_shift = {r_hi, r_lo[W-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opb};
    w_div_ge    = !w_div_diff[W];
    w_rem_next  = w_div_ge ? w_div_diff[W-1:0] : w_div_shift[W-1:0];
    w_quo_next  = {r_lo[W-2:0], w_div_ge};
    if (r_mop[1]) begin
      w_div_res = r_neg ? (~w_rem_next + ONE_W) : w_rem_next;
    end else begin
      w_div_res = r_neg ? (~w_quo_next + ONE_W) : w_quo_next;
    end

    w_last = (r_cnt == CNT_ONE);
  end

  // Next-state selection; flush overrides everything but reset
  always_comb begin
    if (!w_is_m) begin
      w_acc_state = S_DONE;
    end else if (!w_is_div) begin
      w_acc_state = S_MUL;
    end else if (w_special) begin
      w_acc_state = S_DONE;
    end else begin
      w_acc_state = S_DIV;
    end

    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = w_acc_state;
        S_MUL:   if (w_last) w_state_nxt = S_DONE;
        S_DIV:   if (w_last) w_state_nxt = S_DONE;
        S_DONE: begin
          if (out_ready) begin
            w_state_nxt = w_accept ? w_acc_state : S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, iteration and result register; frozen during flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_mop    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (!flush) begin
      if (w_accept) begin
        r_mop <= w_mop[1:0];
        r_neg <= w_neg_acc;
        r_cnt <= CNT_LOAD;
        r_hi  <= '0;
        if (!w_is_m) begin
          r_result <= w_base;
          r_zero   <= (w_base == '0);
        end else if (!w_is_div) begin
          r_lo  <= w_b_mag;
          r_opb <= w_a_mag;
        end else if (w_special) begin
          r_result <= w_special_res;
          r_zero   <= (w_special_res == '0);
        end else begin
          r_lo  <= w_a_mag;
          r_opb <= w_b_mag;
        end
      end else if (r_state == S_MUL) begin
        r_hi  <= w_mul_sum[W:1];
        r_lo  <= {w_mul_sum[0], r_lo[W-1:1]};
        r_cnt <= r_cnt - CNT_ONE;
        if (w_last) begin
          r_result <= w_mul_res;
          r_zero   <= (w_mul_res == '0);
        end
      end else if (r_state == S_DIV) begin
        r_hi  <= w_rem_next;
        r_lo  <= w_quo_next;
        r_cnt <= r_cnt - CNT_ONE;
        if (w_last) begin
          r_result <= w_div_res;
          r_zero   <= (w_div_res == '0);
        end
      end
    end
  end

endmodule
